i2c_tof_responder: RTL and testbench

I2C target (responder) that answers the I2C master block on the shared SCL/SDA bus, emulating the ToF sensor at 7-bit address 0x29 with 16-bit register addressing. Backed by a small internal byte register file with auto-incrementing pointer. Used as the bus-side model/peer for master bring-up and as an in-fabric target for other masters. Write strobes are exposed to the host logic.

---
 rtl/i2c_tof_responder.sv | 131 +++++++++++++
 tb/tb_i2c_tof_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_tof_responder.sv
// i2c_tof_responder: I2C target at SLAVE_ADDRESS with 16-bit register pointer and
// a small auto-incrementing byte register file.
module i2c_tof_responder #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h29,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 SCL_in,
  input  logic                 SDA_in,
  output logic                 SDA_out,
  output logic                 SDA_t,
  output logic                 busy,
  output logic                 wr_valid,
  output logic [15:0]          wr_addr,
  output logic [7:0]           wr_data,
  input  logic [ADDR_BITS-1:0] host_addr,
  output logic [7:0]           host_rdata
);
  localparam int DEPTH = 1 << ADDR_BITS;
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG_HI, REG_HI_ACK, REG_LO, REG_LO_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  state_t state, ack_next;
  logic [2:0] scl_q, sda_q;
  logic [3:0] cnt;
  logic [7:0] sr, rd_byte, byte_in;
  logic [15:0] ptr;
  logic [7:0] mem [DEPTH];
  logic scl, sda, scl_rise, scl_fall, start, stop;
  logic [ADDR_BITS-1:0] idx;
  // [1] is the synchronized level, [2] the previous synchronized level
  assign scl = scl_q[1];
  assign sda = sda_q[1];
  assign scl_rise = scl & ~scl_q[2];
  assign scl_fall = ~scl & scl_q[2];
  assign start = scl & scl_q[2] & sda_q[2] & ~sda;
  assign stop = scl & scl_q[2] & ~sda_q[2] & sda;
  assign idx = ptr[ADDR_BITS-1:0];
  assign rd_byte = mem[idx];
  assign byte_in = {sr[6:0], sda};
  assign host_rdata = mem[host_addr];
  assign SDA_out = 1'b0;
  always_comb ack_next = state == ADDR_ACK ? REG_HI : state == REG_HI_ACK ? REG_LO : WDATA;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      scl_q <= '1;
      sda_q <= '1;
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      ptr <= '0;
      SDA_t <= 1'b1;
      busy <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      scl_q <= {scl_q[1:0], SCL_in};
      sda_q <= {sda_q[1:0], SDA_in};
      wr_valid <= 1'b0;
      if (start) begin
        state <= ADDR;
        cnt <= '0;
        SDA_t <= 1'b1;
      end else if (stop) begin
        state <= IDLE;
        busy <= 1'b0;
        SDA_t <= 1'b1;
      end else if (scl_rise) begin
        cnt <= cnt + 4'd1;
        // the ACK clock (cnt==8) must not disturb the byte held in sr
        if (!cnt[3]) sr <= byte_in;
        case (state)
          ADDR: if (cnt == 4'd7) begin
            state <= byte_in[7:1] == SLAVE_ADDRESS ? ADDR_ACK : IGNORE;
            busy <= byte_in[7:1] == SLAVE_ADDRESS;
          end
          REG_HI: if (cnt == 4'd7) begin
            ptr[15:8] <= byte_in;
            state <= REG_HI_ACK;
          end
          REG_LO: if (cnt == 4'd7) begin
            ptr[7:0] <= byte_in;
            state <= REG_LO_ACK;
          end
          WDATA: if (cnt == 4'd7) begin
            mem[idx] <= byte_in;
            wr_valid <= 1'b1;
            wr_addr <= ptr;
            wr_data <= byte_in;
            ptr <= ptr + 16'd1;
            state <= WDATA_ACK;
          end
          RDATA: if (cnt == 4'd7) state <= RDATA_ACK;
          RDATA_ACK: if (sda) begin
            state <= IGNORE;
            busy <= 1'b0;
          end else ptr <= ptr + 16'd1;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, REG_HI_ACK, REG_LO_ACK, WDATA_ACK:
            if (cnt == 4'd8) SDA_t <= 1'b0;
            else if (state == ADDR_ACK && sr[0]) begin
              state <= RDATA;
              sr <= rd_byte;
              SDA_t <= rd_byte[7];
              cnt <= '0;
            end else begin
              state <= ack_next;
              SDA_t <= 1'b1;
              cnt <= '0;
            end
          RDATA: SDA_t <= sr[7];
          RDATA_ACK:
            if (cnt == 4'd8) SDA_t <= 1'b1;
            else begin
              state <= RDATA;
              sr <= rd_byte;
              SDA_t <= rd_byte[7];
              cnt <= '0;
            end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_i2c_tof_responder.sv
// tb_i2c_tof_responder: bit-banged I2C master driving the responder over a wired-AND SDA.
module tb_i2c_tof_responder;
  localparam int Q = 10;
  logic clock = 1'b0, reset = 1'b0, scl = 1'b1, sda = 1'b1;
  logic SDA_in, SDA_out, SDA_t, busy, wr_valid;
  logic [15:0] wr_addr;
  logic [7:0] wr_data, host_rdata;
  logic [3:0] host_addr = '0;
  int total = 0, bad = 0, wr_n = 0, busy_cnt = 0;
  logic [23:0] wr_log [64];

  always #5 clock = ~clock;
  assign SDA_in = sda & (SDA_t | SDA_out);

  i2c_tof_responder dut (
    .clock(clock), .reset(reset), .SCL_in(scl), .SDA_in(SDA_in), .SDA_out(SDA_out),
    .SDA_t(SDA_t), .busy(busy), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_addr(host_addr), .host_rdata(host_rdata)
  );

  always @(negedge clock) begin
    if (wr_valid) begin
      wr_log[wr_n % 64] <= {wr_addr, wr_data};
      wr_n <= wr_n + 1;
    end
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  typedef struct {
    logic [15:0] ptr;
    logic [7:0] data;
    logic [3:0] idx;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clock);
  endtask

  task automatic i2c_start();
    sda = 1'b1; wq(); scl = 1'b1; wq(); sda = 1'b0; wq(); scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda = 1'b0; wq(); scl = 1'b1; wq(); sda = 1'b1; wq();
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda = b; wq(); scl = 1'b1; wq(); s = SDA_in; wq(); scl = 1'b0; wq();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = !s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  initial begin
    logic a, s;
    logic [3:0] acks;
    logic [4:0] acks5;
    logic [7:0] d;
    int n0, b0;
    vecs[0] = '{16'h0016, 8'hC3, 4'd6, 8'hC3};
    vecs[1] = '{16'hA6A6, 8'h02, 4'd6, 8'h02};
    vecs[2] = '{16'h0003, 8'h5A, 4'd3, 8'h5A};
    vecs[3] = '{16'h000F, 8'h80, 4'd15, 8'h80};

    repeat (4) @(negedge clock);
    check("rst_sda_t", SDA_t, 1);
    check("rst_sda_out", SDA_out, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_host_rdata", host_rdata, 0);
    reset = 1'b1;
    wq();

    for (int v = 0; v < 4; v++) begin
      n0 = wr_n;
      i2c_start();
      wr_byte(8'h52, a); acks = {3'b0, a};
      wr_byte(vecs[v].ptr[15:8], a); acks = {acks[2:0], a};
      wr_byte(vecs[v].ptr[7:0], a); acks = {acks[2:0], a};
      wr_byte(vecs[v].data, a); acks = {acks[2:0], a};
      check("wr_busy", busy, 1);
      i2c_stop();
      check("wr_acks", acks, 4'hF);
      check("wr_count", wr_n - n0, 1);
      check("wr_entry", wr_log[n0 % 64], {vecs[v].ptr, vecs[v].data});
      check("wr_busy_after_stop", busy, 0);
      host_addr = vecs[v].idx;
      @(negedge clock);
      check("wr_host_rdata", host_rdata, vecs[v].exp);
    end

    // pointer 0x0006, repeated START, read mem[6]=0x02 (ACK) then mem[7]=0x00 (NACK)
    n0 = wr_n;
    i2c_start();
    wr_byte(8'h52, a); acks = {3'b0, a};
    wr_byte(8'h00, a); acks = {acks[2:0], a};
    wr_byte(8'h06, a); acks = {acks[2:0], a};
    i2c_start();
    wr_byte(8'h53, a); acks = {acks[2:0], a};
    check("rd_acks", acks, 4'hF);
    read_byte(1'b0, d);
    check("rd_byte0", d, 8'h02);
    check("rd_busy", busy, 1);
    read_byte(1'b1, d);
    check("rd_byte1", d, 8'h00);
    check("rd_release", SDA_t, 1);
    check("rd_busy_nack", busy, 0);
    i2c_stop();
    check("rd_no_write", wr_n - n0, 0);

    // address mismatch: nothing acked, busy never set, later byte ignored
    n0 = wr_n; b0 = busy_cnt;
    i2c_start();
    wr_byte(8'h60, a);
    check("mm_addr_ack", a, 0);
    wr_byte(8'h52, a);
    check("mm_data_ack", a, 0);
    i2c_stop();
    check("mm_busy_cycles", busy_cnt - b0, 0);
    check("mm_no_write", wr_n - n0, 0);

    // abort: STOP after 4 data bits of a write byte to pointer 0x0005
    n0 = wr_n;
    i2c_start();
    wr_byte(8'h52, a); wr_byte(8'h00, a); wr_byte(8'h05, a);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
    i2c_stop();
    check("ab_no_write", wr_n - n0, 0);
    check("ab_sda_t", SDA_t, 1);
    check("ab_busy", busy, 0);
    host_addr = 4'd5;
    @(negedge clock);
    check("ab_mem5", host_rdata, 8'h00);

    // burst write across pointer wrap 0xFFFF -> 0x0000
    n0 = wr_n;
    i2c_start();
    wr_byte(8'h52, a); acks5 = {4'b0, a};
    wr_byte(8'hFF, a); acks5 = {acks5[3:0], a};
    wr_byte(8'hFF, a); acks5 = {acks5[3:0], a};
    wr_byte(8'h11, a); acks5 = {acks5[3:0], a};
    wr_byte(8'h22, a); acks5 = {acks5[3:0], a};
    i2c_stop();
    check("wrap_acks", acks5, 5'h1F);
    check("wrap_count", wr_n - n0, 2);
    check("wrap_entry0", wr_log[n0 % 64], 24'hFFFF11);
    check("wrap_entry1", wr_log[(n0 + 1) % 64], 24'h000022);
    host_addr = 4'd15;
    @(negedge clock);
    check("wrap_mem15", host_rdata, 8'h11);
    host_addr = 4'd0;
    @(negedge clock);
    check("wrap_mem0", host_rdata, 8'h22);

    // reset while driving bit 7 (=0) of mem[0]=0x22
    i2c_start();
    wr_byte(8'h52, a); wr_byte(8'h00, a); wr_byte(8'h00, a);
    i2c_start();
    wr_byte(8'h53, a);
    check("rs_pre_drive", SDA_t, 0);
    check("rs_pre_busy", busy, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rs_sda_t", SDA_t, 1);
    check("rs_busy", busy, 0);
    check("rs_wr_valid", wr_valid, 0);
    check("rs_wr_addr", wr_addr, 0);
    check("rs_wr_data", wr_data, 0);
    host_addr = 4'd0;
    #1;
    check("rs_mem0", host_rdata, 8'h00);
    host_addr = 4'd15;
    #1;
    check("rs_mem15", host_rdata, 8'h00);
    wq();
    reset = 1'b1;
    i2c_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
